// File: rtl/timreg_sync_pkg.sv
// Shared timebase definitions: bus width from core configuration and the
// Gray-code conversions used on both sides of the q_gray crossing.
package timreg_sync_pkg;

  localparam int unsigned CORE_XLEN = 64;
  localparam int unsigned CNT_W     = 64;

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/timreg_sync_sync.sv
// Generic 1-bit 2-flop synchronizer, cleared asynchronously to 0.
// Latency: 2 clk edges from d to q.
module timreg_sync_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/timreg_sync.sv
// Free-running 64-bit machine-time counter in the timebase domain, written via a
// four-phase req/ack handshake; exports a registered Gray copy for the readers.
module timreg_sync
  import timreg_sync_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             we0,
  input  logic             we1,
  input  logic [XLEN-1:0]  wd,
  output logic             ack,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] q_gray
);

  logic             run;
  logic             ack_d_q;
  logic             wr_evt;
  logic             wr_en;
  logic [CNT_W-1:0] wr_val;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] gray_q;

  // Async-assert / sync-deassert: run rises two edges after resetn releases.
  timreg_sync_sync u_rst_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (1'b1),
    .q     (run)
  );

  timreg_sync_sync u_req_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (req),
    .q     (ack)
  );

  // One write per handshake no matter how long req stays high.
  assign wr_evt = ack & ~ack_d_q;

  if (XLEN == 64) begin : g_x64
    logic unused_we1;
    assign unused_we1 = we1;
    assign wr_en      = we0;
    assign wr_val     = CNT_W'(wd);
  end else if (XLEN == 32) begin : g_x32
    assign wr_en  = we0 | we1;
    assign wr_val = we0 ? {cnt_q[63:32], wd[31:0]} : {wd[31:0], cnt_q[31:0]};
  end else begin : g_bad
    $error("timreg_sync: XLEN must be 32 or 64");
  end

  always_comb begin
    cnt_d = cnt_q + 64'd1;
    if (wr_evt && wr_en) begin
      cnt_d = wr_val;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      gray_q  <= '0;
      ack_d_q <= 1'b0;
    end else begin
      ack_d_q <= ack;
      gray_q  <= bin2gray(cnt_q);
      if (run) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign q      = cnt_q;
  assign q_gray = gray_q;

endmodule

// File: tb/tb_timreg_sync.sv
// Directed bench for timreg_sync: one XLEN=64 and one XLEN=32 instance share
// the clock, reset and handshake wires.
module tb_timreg_sync;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        we0;
  logic        we1;
  logic [63:0] wd64;
  logic [31:0] wd32;
  logic        ack64;
  logic        ack32;
  logic [63:0] q64;
  logic [63:0] g64;
  logic [63:0] q32;
  logic [63:0] g32;

  int errors = 0;
  int checks = 0;

  timreg_sync #(.XLEN(64)) u_d64 (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .we0    (we0),
    .we1    (we1),
    .wd     (wd64),
    .ack    (ack64),
    .q      (q64),
    .q_gray (g64)
  );

  timreg_sync #(.XLEN(32)) u_d32 (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .we0    (we0),
    .we1    (we1),
    .wd     (wd32),
    .ack    (ack32),
    .q      (q32),
    .q_gray (g32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] tb_g2b(input logic [63:0] g);
    logic [63:0] b;
    b = g;
    for (int s = 1; s < 64; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Full handshake: write lands on the 3rd edge, ack is low again 2 edges after req drops.
  task automatic do_write(input logic w0, input logic w1, input logic [63:0] d64,
                          input logic [31:0] d32);
    we0 = w0; we1 = w1; wd64 = d64; wd32 = d32;
    req = 1'b1;
    repeat (3) tick();
    req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b0; we0 = 1'b0; we1 = 1'b0; wd64 = '0; wd32 = '0;
    repeat (3) tick();
    checks++; if (q64 !== 64'd0) begin errors++; $display("FAIL reset_q64: got %h want 0", q64); end
    checks++; if (g64 !== 64'd0) begin errors++; $display("FAIL reset_gray: got %h want 0", g64); end
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack64); end
    checks++; if (q32 !== 64'd0) begin errors++; $display("FAIL reset_q32: got %h want 0", q32); end
    resetn = 1'b1;
    tick();
    checks++; if (q64 !== 64'd0) begin errors++; $display("FAIL release_e1: got %h want 0", q64); end
    tick();
    checks++; if (q64 !== 64'd0) begin errors++; $display("FAIL release_e2: got %h want 0", q64); end
    tick();
    checks++; if (q64 !== 64'd1) begin errors++; $display("FAIL release_e3: got %h want 1", q64); end
    tick();
    checks++; if (q64 !== 64'd2) begin errors++; $display("FAIL release_e4: got %h want 2", q64); end
  endtask

  task automatic test_write64();
    logic [63:0] v;
    v = 64'h0123_4567_89AB_CDEF;
    we0 = 1'b1; we1 = 1'b0; wd64 = v; wd32 = 32'h0;
    req = 1'b1;
    tick();
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL w64_ack_e1: got %b want 0", ack64); end
    tick();
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL w64_ack_e2: got %b want 1", ack64); end
    tick();
    checks++; if (q64 !== v) begin errors++; $display("FAIL w64_q: got %h want %h", q64, v); end
    tick();
    checks++; if (q64 !== v + 64'd1) begin errors++; $display("FAIL w64_inc: got %h want %h", q64, v + 64'd1); end
    repeat (20) tick();
    checks++; if (q64 !== v + 64'd21) begin errors++; $display("FAIL w64_hold: got %h want %h", q64, v + 64'd21); end
    req = 1'b0;
    tick();
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL w64_ackfall1: got %b want 1", ack64); end
    tick();
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL w64_ackfall2: got %b want 0", ack64); end
    checks++; if (q64 !== v + 64'd23) begin errors++; $display("FAIL w64_after: got %h want %h", q64, v + 64'd23); end
  endtask

  task automatic test_split32();
    logic [63:0] before64;
    before64 = q64;
    do_write(1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 32'hDEAD_BEEF);
    checks++; if (q64 !== before64 + 64'd5) begin errors++; $display("FAIL x64_we1_ignored: got %h want %h", q64, before64 + 64'd5); end
    checks++; if (q32[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x32_upper: got %h want deadbeef", q32[63:32]); end
    do_write(1'b1, 1'b0, 64'h0, 32'hFFFF_FFF0);
    checks++; if (q32 !== 64'hDEAD_BEEF_FFFF_FFF2) begin errors++; $display("FAIL x32_lower: got %h want deadbeeffffffff2", q32); end
    repeat (13) tick();
    checks++; if (q32 !== 64'hDEAD_BEEF_FFFF_FFFF) begin errors++; $display("FAIL x32_pre_carry: got %h want deadbeefffffffff", q32); end
    tick();
    checks++; if (q32 !== 64'hDEAD_BEF0_0000_0000) begin errors++; $display("FAIL x32_carry: got %h want deadbef000000000", q32); end
  endtask

  task automatic test_priority_noop();
    logic [31:0] up;
    logic [63:0] before64;
    up = q32[63:32];
    do_write(1'b1, 1'b1, 64'h0, 32'h1234_5678);
    checks++; if (q32 !== {up, 32'h1234_567A}) begin errors++; $display("FAIL x32_we0_prio: got %h want %h", q32, {up, 32'h1234_567A}); end
    before64 = q64;
    do_write(1'b0, 1'b0, 64'h5A5A_5A5A_5A5A_5A5A, 32'h5A5A_5A5A);
    checks++; if (q64 !== before64 + 64'd5) begin errors++; $display("FAIL noop_write: got %h want %h", q64, before64 + 64'd5); end
  endtask

  task automatic test_wrap();
    we0 = 1'b1; we1 = 1'b0; wd64 = 64'hFFFF_FFFF_FFFF_FFFE; wd32 = 32'h0;
    req = 1'b1;
    repeat (3) tick();
    req = 1'b0;
    checks++; if (q64 !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL wrap_q0: got %h want fffffffffffffffe", q64); end
    tick();
    checks++; if (q64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_q1: got %h want ffffffffffffffff", q64); end
    checks++; if (g64 !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL wrap_g1: got %h want 8000000000000001", g64); end
    tick();
    checks++; if (q64 !== 64'd0) begin errors++; $display("FAIL wrap_q2: got %h want 0", q64); end
    checks++; if (g64 !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL wrap_g2: got %h want 8000000000000000", g64); end
    checks++; if (tb_g2b(g64) !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_dec2: got %h want ffffffffffffffff", tb_g2b(g64)); end
    tick();
    checks++; if (q64 !== 64'd1) begin errors++; $display("FAIL wrap_q3: got %h want 1", q64); end
    checks++; if (g64 !== 64'd0) begin errors++; $display("FAIL wrap_g3: got %h want 0", g64); end
    tick();
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL wrap_ack_low: got %b want 0", ack64); end
  endtask

  task automatic test_gray();
    logic [63:0] pq;
    logic [63:0] pg;
    pq = q64; pg = g64;
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++; if ($countones(g64 ^ pg) != 1) begin errors++; $display("FAIL gray_onebit[%0d]: got %h prev %h", i, g64, pg); end
      checks++; if (tb_g2b(g64) !== pq) begin errors++; $display("FAIL gray_decode[%0d]: got %h want %h", i, tb_g2b(g64), pq); end
      pq = q64; pg = g64;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    v = 64'h5555_0000_1111_2222;
    we0 = 1'b1; we1 = 1'b0; wd64 = v; wd32 = 32'h0;
    req = 1'b1;
    repeat (2) tick();
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL mid_ack_up: got %b want 1", ack64); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL mid_ack_clr: got %b want 0", ack64); end
    checks++; if (q64 !== 64'd0) begin errors++; $display("FAIL mid_q_clr: got %h want 0", q64); end
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    checks++; if (ack64 !== 1'b0 || q64 !== 64'd0) begin errors++; $display("FAIL mid_e1: got ack=%b q=%h want ack=0 q=0", ack64, q64); end
    tick();
    checks++; if (ack64 !== 1'b1 || q64 !== 64'd0) begin errors++; $display("FAIL mid_e2: got ack=%b q=%h want ack=1 q=0", ack64, q64); end
    tick();
    checks++; if (q64 !== v) begin errors++; $display("FAIL mid_write: got %h want %h", q64, v); end
    tick();
    req = 1'b0;
    repeat (2) tick();
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL mid_ack_fall: got %b want 0", ack64); end
    checks++; if (q64 !== v + 64'd3) begin errors++; $display("FAIL mid_single_write: got %h want %h", q64, v + 64'd3); end
  endtask

  initial begin
    test_reset();
    test_write64();
    test_split32();
    test_priority_noop();
    test_wrap();
    test_gray();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
